// File: rtl/picobello_int_offload_alu.sv
// Integer reduction ALU behind the router's offload-reduction port.
// One op in flight; multiply runs a fixed-latency countdown.
package picobello_int_offload_alu_pkg;
  typedef enum logic [3:0] {
    R_Select = 4'd0,
    F_Add    = 4'd4,
    F_Mul    = 4'd5,
    F_Min    = 4'd6,
    F_Max    = 4'd7,
    A_Add    = 4'd8,
    A_Mul    = 4'd9,
    A_Min_S  = 4'd10,
    A_Max_S  = 4'd11,
    A_Min_U  = 4'd14,
    A_Max_U  = 4'd15
  } reduction_op_e;
endpackage

module picobello_int_offload_alu
  import picobello_int_offload_alu_pkg::*;
#(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned MulLatency = 3,
  parameter int unsigned CntWidth   = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0][DataWidth-1:0] req_operands_i,
  input  logic [3:0]                req_op_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  output logic [DataWidth-1:0]      resp_result_o,
  output logic                      resp_err_o,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [CntWidth-1:0]       ops_count_o
);

  if (MulLatency < 1 || MulLatency > 8) begin : g_bad_latency
    $error("MulLatency must be within 1..8");
  end

  typedef enum logic [1:0] {Idle, Busy, Resp} state_e;
  localparam int unsigned BW = 4;

  state_e               state_q, state_d;
  logic [BW-1:0]        cnt_q, cnt_d;
  logic [DataWidth-1:0] opa_q, opa_d;
  logic [DataWidth-1:0] opb_q, opb_d;
  logic [DataWidth-1:0] res_q, res_d;
  logic                 err_q, err_d;
  logic [CntWidth-1:0]  ops_q, ops_d;

  logic [DataWidth-1:0] a, b, alu_res, mul_res;
  logic                 alu_err, is_mul, accept, resp_hs;

  assign a       = req_operands_i[0];
  assign b       = req_operands_i[1];
  assign is_mul  = (req_op_i == A_Mul);
  assign mul_res = opa_q * opb_q;

  // Gated by reset so ready stays low while rst_ni is held.
  assign req_ready_o = rst_ni & ((state_q == Idle) |
                       ((state_q == Resp) & resp_ready_i));
  assign resp_valid_o = (state_q == Resp);
  assign accept  = req_valid_i & req_ready_o;
  assign resp_hs = resp_valid_o & resp_ready_i;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    unique case (req_op_i)
      R_Select: alu_res = a;
      A_Add:    alu_res = a + b;
      A_Mul:    alu_res = (MulLatency == 1) ? a * b : '0;
      A_Min_S:  alu_res = ($signed(b) < $signed(a)) ? b : a;
      A_Max_S:  alu_res = ($signed(b) > $signed(a)) ? b : a;
      A_Min_U:  alu_res = (b < a) ? b : a;
      A_Max_U:  alu_res = (b > a) ? b : a;
      default:  alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    err_d   = err_q;
    ops_d   = ops_q + CntWidth'(resp_hs);
    unique case (state_q)
      Idle, Resp: begin
        if (resp_hs) state_d = Idle;
        if (accept) begin
          if (is_mul && MulLatency > 1) begin
            opa_d   = a;
            opb_d   = b;
            cnt_d   = BW'(MulLatency - 1);
            state_d = Busy;
          end else begin
            res_d   = alu_res;
            err_d   = alu_err;
            state_d = Resp;
          end
        end
      end
      Busy: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == BW'(1)) begin
          res_d   = mul_res;
          err_d   = 1'b0;
          state_d = Resp;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      err_q   <= err_d;
      ops_q   <= ops_d;
    end
  end

  assign resp_result_o = res_q;
  assign resp_err_o    = err_q;
  assign ops_count_o   = ops_q;

endmodule
